seq_detect_prog: RTL and testbench

//   Programmable serial bit-sequence detector with a Moore-style registered output.

---
 rtl/seq_detect_prog_if.sv | 38 +++
 rtl/seq_detect_prog.sv | 91 +++++++++
 tb/tb_seq_detect_prog.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_prog_if.sv
// Purpose: groups the configuration, stream, counter-clear and result signals of
//          the programmable sequence detector into one bundle.
// Signals:
//   cfg_load     latch cfg_pattern/cfg_len/cfg_ovl this cycle
//   cfg_pattern  pattern, bit [len-1] is the first bit received
//   cfg_len      pattern length in bits (0 disables, >MAX_LEN clamps)
//   cfg_ovl      1 = overlapping detection
//   in_valid     in carries a valid stream bit
//   in           serial data bit
//   cnt_clr      synchronous clear of match_count
//   detect       registered match flag
//   match_count  saturating match counter
// Modports: master drives config/stream, slave is the detector.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               in_valid;
    logic               in;
    logic               cnt_clr;
    logic               detect;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_ovl, in_valid, in, cnt_clr,
        input  detect, match_count
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_ovl, in_valid, in, cnt_clr,
        output detect, match_count
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Purpose: programmable serial bit-sequence detector with a registered (Moore)
//          match flag and a saturating match counter. Pattern, length and
//          overlap mode are loaded at runtime.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  seq_detect_prog_if.slave: config, stream, cnt_clr, detect, match_count
//
// State  | meaning
// hist   | last MAX_LEN accepted bits, newest at [0]
// hist_cnt | number of usable bits in hist (0..MAX_LEN); zeroed after a
//          | non-overlapping match so matched bits cannot be reused
// detect | result of the most recent accepted beat
module seq_detect_prog #(
    parameter int               MAX_LEN     = 8,
    parameter int               LEN_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'h09),
    parameter int               RST_LEN     = 4,
    parameter logic             RST_OVL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_prog_if.slave   bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   hist_cnt;
    logic               detect_q;
    logic [CNT_W-1:0]   count_q;

    logic               accept;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   cnt_inc;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic [LEN_W-1:0]   len_clamped;

    always_comb begin
        // A config load in the same cycle takes priority and drops the beat.
        accept      = bus.in_valid && !bus.cfg_load;
        hist_nxt    = {hist[MAX_LEN-2:0], bus.in};
        cnt_inc     = (hist_cnt >= MAX_LEN_L) ? MAX_LEN_L : hist_cnt + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        match       = accept && (len != '0) && (cnt_inc >= len) &&
                      (((hist_nxt ^ pattern) & mask) == '0);
        len_clamped = (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern  <= RST_PATTERN;
            len      <= LEN_W'(RST_LEN);
            ovl      <= RST_OVL;
            hist     <= '0;
            hist_cnt <= '0;
            detect_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (bus.cfg_load) begin
                pattern  <= bus.cfg_pattern;
                len      <= len_clamped;
                ovl      <= bus.cfg_ovl;
                hist_cnt <= '0;
                detect_q <= 1'b0;
            end else if (bus.in_valid) begin
                hist     <= hist_nxt;
                hist_cnt <= (match && !ovl) ? '0 : cnt_inc;
                detect_q <= match;
            end

            // Clear beats a simultaneous match.
            if (bus.cnt_clr) begin
                count_q <= '0;
            end else if (match && !(&count_q)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.detect      = detect_q;
    assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_ovl = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cnt_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idx = 0;
    string tag = "rst";

    typedef struct {
        int    due;
        logic  det;
        int    cnt;
        int    sat;
        string name;
    } exp_t;

    exp_t sb[$];

    seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus_a ();
    seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus_b ();

    assign bus_a.cfg_load = cfg_load;    assign bus_b.cfg_load = cfg_load;
    assign bus_a.cfg_pattern = cfg_pattern; assign bus_b.cfg_pattern = cfg_pattern;
    assign bus_a.cfg_len = cfg_len;      assign bus_b.cfg_len = cfg_len;
    assign bus_a.cfg_ovl = cfg_ovl;      assign bus_b.cfg_ovl = cfg_ovl;
    assign bus_a.in_valid = in_valid;    assign bus_b.in_valid = in_valid;
    assign bus_a.in = in_bit;            assign bus_b.in = in_bit;
    assign bus_a.cnt_clr = cnt_clr;      assign bus_b.cnt_clr = cnt_clr;

    seq_detect_prog #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
    seq_detect_prog #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Monitor: outputs settle after the posedge; compare at the following negedge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk({e.name, " missed"}, cyc, e.due);
            end else begin
                chk({e.name, " det"}, int'(bus_a.detect), int'(e.det));
                chk({e.name, " cnt"}, int'(bus_a.match_count), e.cnt);
                if (e.sat >= 0) chk({e.name, " sat"}, int'(bus_b.match_count), e.sat);
            end
        end
    end

    task automatic expect_next(input logic e_det, input int e_cnt, input int e_sat);
        sb.push_back('{cyc + 1, e_det, e_cnt, e_sat, $sformatf("%s#%0d", tag, idx)});
        idx++;
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic beat(input logic b, input logic e_det, input int e_cnt,
                        input int e_sat = -1, input logic clr = 1'b0);
        in_valid = 1'b1;
        in_bit   = b;
        cnt_clr  = clr;
        expect_next(e_det, e_cnt, e_sat);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                        input logic clr, input int e_cnt, input int e_sat = -1,
                        input logic v = 1'b0, input logic b = 1'b0);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = ln;
        cfg_ovl     = ov;
        cnt_clr     = clr;
        in_valid    = v;
        in_bit      = b;
        expect_next(1'b0, e_cnt, e_sat);
    endtask

    task automatic gap(input int n, input logic e_det, input int e_cnt);
        for (int i = 0; i < n; i++) expect_next(e_det, e_cnt, -1);
    endtask

    task automatic do_reset(input string nm);
        #2 rst = 1'b0;
        #1;
        chk({nm, " det"}, int'(bus_a.detect), 0);
        chk({nm, " cnt"}, int'(bus_a.match_count), 0);
        chk({nm, " sat"}, int'(bus_b.match_count), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst det", int'(bus_a.detect), 0);
        chk("rst cnt", int'(bus_a.match_count), 0);
        rst = 1'b1;
        @(negedge clk);

        // Defaults 1001, non-overlapping
        tag = "t1";
        beat(1, 0, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 1, 1);
        beat(0, 0, 1); beat(0, 0, 1); beat(1, 0, 1);

        // Overlapping, count cleared in the load cycle
        tag = "t2";
        load(8'h09, 4'd4, 1'b1, 1'b1, 0);
        beat(1, 0, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 1, 1);
        beat(0, 0, 1); beat(0, 0, 1); beat(1, 1, 2);

        // 111, overlapping: detect held high across back-to-back matches
        tag = "t3a";
        load(8'h07, 4'd3, 1'b1, 1'b1, 0);
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 1, 1); beat(1, 1, 2); beat(1, 1, 3);

        tag = "t3b";
        load(8'h07, 4'd3, 1'b0, 1'b1, 0);
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 1, 1); beat(1, 0, 1); beat(1, 0, 1);

        // Gaps between beats: detect only moves on accepted beats
        tag = "t4";
        load(8'h09, 4'd4, 1'b0, 1'b1, 0);
        beat(1, 0, 0); gap(3, 0, 0);
        beat(0, 0, 0); gap(3, 0, 0);
        beat(0, 0, 0); gap(3, 0, 0);
        beat(1, 1, 1); gap(3, 1, 1);
        beat(0, 0, 1);

        // len=0 disables detection
        tag = "len0";
        load(8'h00, 4'd0, 1'b0, 1'b0, 1);
        beat(0, 0, 1); beat(0, 0, 1); beat(1, 0, 1); beat(0, 0, 1);

        // len=15 clamps to 8
        tag = "clamp";
        load(8'hA5, 4'd15, 1'b0, 1'b0, 1);
        beat(1, 0, 1); beat(0, 0, 1); beat(1, 0, 1); beat(0, 0, 1);
        beat(0, 0, 1); beat(1, 0, 1); beat(0, 0, 1); beat(1, 1, 2);

        // Pattern bits above len are ignored
        tag = "upper";
        load(8'hF5, 4'd3, 1'b0, 1'b0, 2);
        beat(1, 0, 2); beat(0, 0, 2); beat(1, 1, 3);

        // Saturation of the 2-bit counter, clear beats a simultaneous match
        tag = "t5";
        load(8'h01, 4'd1, 1'b1, 1'b1, 0, 0);
        beat(1, 1, 1, 1); beat(1, 1, 2, 2); beat(1, 1, 3, 3);
        beat(1, 1, 4, 3); beat(1, 1, 5, 3);
        beat(1, 1, 0, 0, 1'b1);
        beat(1, 1, 1, 1);
        beat(0, 0, 1, 1);

        // Async reset mid-stream restores defaults and drops partial matches
        tag = "t6";
        load(8'h07, 4'd3, 1'b1, 1'b0, 1, 1);
        beat(1, 0, 1, 1); beat(1, 0, 1, 1); beat(1, 1, 2, 2);
        do_reset("rst1");
        beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0);
        do_reset("rst2");
        tag = "t6r";
        beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(1, 1, 1, 1);

        // Load with a simultaneous valid beat: the beat is dropped
        tag = "t6b";
        load(8'h09, 4'd4, 1'b0, 1'b0, 1, 1, 1'b1, 1'b1);
        beat(0, 0, 1); beat(0, 0, 1); beat(1, 0, 1);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) chk("drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d expected=0", sb.size());
        $fatal(1, "timeout");
    end

endmodule
